maxpool2x2_stream: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU stage and consumes its raster-order signed INT8 feature stream. It buffers half a row of partial maxima, so full feature-map rows are never stored. For every completed 2×2 block it emits one pooled INT8 value, plus an end-of-frame pulse. It is the alternative output stage to the 3×3 feature window/pool path and feeds the top-level `dout`/`valid_out`.

---
 rtl/maxpool2x2_stream_if.sv | 22 ++
 rtl/maxpool2x2_stream.sv | 135 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2x2_stream_if.sv
// Pixel-in / pooled-out signal bundle for the 2x2 max-pooling stage.
// The master side drives pixels and frame dimensions; the slave side returns pooled results.
interface maxpool2x2_stream_if;
    logic              valid_in;
    logic signed [7:0] din;
    logic        [7:0] img_width;
    logic        [7:0] img_height;
    logic signed [7:0] dout;
    logic              valid_out;
    logic              frame_done;
    logic              cfg_err;

    modport master (
        output valid_in, din, img_width, img_height,
        input  dout, valid_out, frame_done, cfg_err
    );

    modport slave (
        input  valid_in, din, img_width, img_height,
        output dout, valid_out, frame_done, cfg_err
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed INT8 max-pool over a raster-order pixel stream.
// Only half a row of partial maxima is buffered; frames wider than MAX_WIDTH are drained.
module maxpool2x2_stream #(
    parameter int unsigned MAX_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    maxpool2x2_stream_if.slave   io_bus
);

    localparam int unsigned Depth = MAX_WIDTH / 2;
    localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [8:0]  MaxW  = 9'(MAX_WIDTH);

    typedef enum logic [1:0] {StIdle, StActive, StDrainErr} state_e;

    state_e            r_state, w_state_nxt;
    logic        [7:0] r_w, r_h, r_col, r_row;
    logic        [7:0] w_w_nxt, w_h_nxt, w_col_nxt, w_row_nxt;
    logic signed [7:0] r_hold, w_hold_nxt;
    logic signed [7:0] r_dout, w_dout_nxt;
    logic              r_valid_out, w_valid_nxt;
    logic              r_frame_done, w_done_nxt;
    logic              r_cfg_err, w_err_nxt;
    logic signed [7:0] r_lbuf [Depth];

    logic        [7:0] w_w, w_h, w_col, w_row;
    logic              w_start, w_zero, w_drain, w_col_last, w_row_last;
    logic              w_lbuf_we;
    logic [IdxW-1:0]   w_idx;
    logic signed [7:0] w_pair;

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // In IDLE the incoming pixel is (0,0) of a new frame using the live dimensions.
    assign w_start    = (r_state == StIdle);
    assign w_zero     = (io_bus.img_width == 8'd0) || (io_bus.img_height == 8'd0);
    assign w_w        = w_start ? (w_zero ? 8'd1 : io_bus.img_width)  : r_w;
    assign w_h        = w_start ? (w_zero ? 8'd1 : io_bus.img_height) : r_h;
    assign w_col      = w_start ? 8'd0 : r_col;
    assign w_row      = w_start ? 8'd0 : r_row;
    assign w_drain    = w_start ? ({1'b0, io_bus.img_width} > MaxW) : (r_state == StDrainErr);
    assign w_col_last = (w_col == w_w - 8'd1);
    assign w_row_last = (w_row == w_h - 8'd1);
    assign w_idx      = w_col[IdxW:1];
    assign w_pair     = smax(r_hold, io_bus.din);

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_h_nxt     = r_h;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_hold_nxt  = r_hold;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_cfg_err;
        w_lbuf_we   = 1'b0;

        if (io_bus.valid_in) begin
            if (w_start) begin
                w_w_nxt     = w_w;
                w_h_nxt     = w_h;
                w_state_nxt = w_drain ? StDrainErr : StActive;
            end
            if (w_drain) begin
                w_err_nxt = 1'b1;
            end else if (!w_col[0]) begin
                w_hold_nxt = io_bus.din;
            end else if (!w_row[0]) begin
                w_lbuf_we = 1'b1;
            end else begin
                w_dout_nxt  = smax(r_lbuf[w_idx], w_pair);
                w_valid_nxt = 1'b1;
            end

            if (w_col_last) begin
                w_col_nxt = 8'd0;
                if (w_row_last) begin
                    w_row_nxt   = 8'd0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_row_nxt = w_row + 8'd1;
                end
            end else begin
                w_col_nxt = w_col + 8'd1;
                w_row_nxt = w_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_w          <= 8'd0;
            r_h          <= 8'd0;
            r_col        <= 8'd0;
            r_row        <= 8'd0;
            r_hold       <= 8'sd0;
            r_dout       <= 8'sd0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_w          <= w_w_nxt;
            r_h          <= w_h_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_hold       <= w_hold_nxt;
            r_dout       <= w_dout_nxt;
            r_valid_out  <= w_valid_nxt;
            r_frame_done <= w_done_nxt;
            r_cfg_err    <= w_err_nxt;
        end
    end

    // Line buffer carries no reset; every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (w_lbuf_we) begin
            r_lbuf[w_idx] <= w_pair;
        end
    end

    assign io_bus.dout       = r_dout;
    assign io_bus.valid_out  = r_valid_out;
    assign io_bus.frame_done = r_frame_done;
    assign io_bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: the driver pushes expected pooled values and
// frame_done cycles from a 2-D reference model; a negedge monitor pops and compares.
module tb_maxpool2x2_stream;

    localparam int unsigned MaxWidth = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    maxpool2x2_stream_if bus ();

    maxpool2x2_stream #(.MAX_WIDTH(MaxWidth)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t              exp_q[$];
    int                done_q[$];
    logic signed [7:0] fr[$];
    exp_t              mon_e;
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor: pop on every output pulse, flag pulses that never showed up.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected valid_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dout", int'(bus.dout), mon_e.val);
                    check("valid_out cycle", cyc, mon_e.at);
                end
            end
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                check("missing valid_out", 0, 1);
                void'(exp_q.pop_front());
            end
            if (bus.frame_done) begin
                if (done_q.size() == 0) check("unexpected frame_done", 1, 0);
                else check("frame_done cycle", cyc, done_q.pop_front());
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
                check("missing frame_done", 0, 1);
                void'(done_q.pop_front());
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            bus.din      = 8'($urandom);
        end
    endtask

    // gap: 0 none, 1 one idle cycle between pixels, 2 random gaps. nlim < 0 means full frame.
    task automatic run_frame(input int w, input int h, input int gap, input int nlim);
        int ew, eh, n, r, c, v;
        bit drain;
        ew    = (w == 0 || h == 0) ? 1 : w;
        eh    = (w == 0 || h == 0) ? 1 : h;
        n     = ew * eh;
        if (nlim >= 0 && nlim < n) n = nlim;
        drain = (w > int'(MaxWidth));
        for (int p = 0; p < n; p++) begin
            if (gap == 1 && p > 0) idle(1);
            if (gap == 2 && $urandom_range(3) == 0) idle($urandom_range(1, 3));
            @(negedge clk);
            bus.valid_in = 1'b1;
            bus.din      = fr[p];
            if (p == 0) begin
                bus.img_width  = 8'(w);
                bus.img_height = 8'(h);
            end else begin
                bus.img_width  = 8'($urandom);
                bus.img_height = 8'($urandom);
            end
            r = p / ew;
            c = p % ew;
            if (!drain && (r % 2 == 1) && (c % 2 == 1)) begin
                v = mx(mx(fr[(r - 1) * ew + c - 1], fr[(r - 1) * ew + c]),
                       mx(fr[r * ew + c - 1], fr[r * ew + c]));
                exp_q.push_back('{val: v, at: cyc + 1});
            end
            if (p == ew * eh - 1) done_q.push_back(cyc + 1);
        end
    endtask

    task automatic fill_ramp(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    endtask

    initial begin
        int w, h;
        bus.valid_in   = 1'b0;
        bus.din        = 8'sd0;
        bus.img_width  = 8'd0;
        bus.img_height = 8'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dout", int'(bus.dout), 0);
        check("reset valid_out", int'(bus.valid_out), 0);
        check("reset frame_done", int'(bus.frame_done), 0);
        check("reset cfg_err", int'(bus.cfg_err), 0);
        rst_n = 1'b1;

        fill_ramp(16);
        run_frame(4, 4, 0, -1);
        idle(2);

        fr.delete();
        fr = '{-8'sd5, -8'sd3, -8'sd8, -8'sd1, -8'sd7, -8'sd2, -8'sd6, -8'sd4};
        run_frame(4, 2, 0, -1);
        idle(2);

        fill_ramp(25);
        run_frame(5, 5, 1, -1);
        idle(2);

        fr = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        run_frame(2, 2, 0, -1);
        fr = '{8'sd9, 8'sd8, 8'sd7, 8'sd6};
        run_frame(2, 2, 0, -1);
        idle(3);
        check("cfg_err clear after legal frames", int'(bus.cfg_err), 0);

        for (int f = 0; f < 24; f++) begin
            w = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 12);
            h = $urandom_range(0, 8);
            if (f == 10) begin
                w = MaxWidth;
                h = 3;
            end
            fill_rand(((w == 0 || h == 0) ? 1 : w * h));
            run_frame(w, h, $urandom_range(0, 2), -1);
        end
        idle(3);
        check("cfg_err clear at MAX_WIDTH", int'(bus.cfg_err), 0);

        fill_rand(140);
        run_frame(70, 2, 0, -1);
        idle(2);
        check("cfg_err set by wide frame", int'(bus.cfg_err), 1);
        fr = '{8'sd0, 8'sd0, 8'sd0, 8'sd3};
        run_frame(2, 2, 0, -1);
        idle(3);
        check("cfg_err sticky", int'(bus.cfg_err), 1);

        fill_ramp(16);
        run_frame(4, 4, 0, 6);
        idle(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset valid_out", int'(bus.valid_out), 0);
        check("async reset dout", int'(bus.dout), 0);
        check("async reset cfg_err", int'(bus.cfg_err), 0);
        check("aborted frame leftover outputs", exp_q.size(), 0);
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        fill_ramp(16);
        run_frame(4, 4, 0, -1);
        idle(5);

        check("pending valid_out at end", exp_q.size(), 0);
        check("pending frame_done at end", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
